display_mode_ctrl: RTL and testbench

Display-mode controller between the Cortex-M3 GPIO outputs and the dual-camera graphics pipeline. Synchronizes and debounces three raw GPIO request lines (camera 0 enable, camera 1 enable, splicing enable), decodes them into one of four display modes, and applies a new mode only at a frame boundary. Outputs are held blanked for a programmable number of frames after each switch so the pipeline can flush. Drives the graphics unit's `cmos0_en`, `cmos1_en` and `splicing_en` inputs.

---
 rtl/display_mode_pkg.sv | 44 ++++
 rtl/display_mode_ctrl_sync_debounce.sv | 72 +++++++
 rtl/display_mode_ctrl.sv | 130 +++++++++++++
 tb/tb_display_mode_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_mode_pkg.sv
// Shared types for the display-mode controller: applied modes, controller states
// and the request/enable decode helpers.
package display_mode_pkg;

  typedef enum logic [1:0] {
    MODE_NONE  = 2'd0,
    MODE_CAM0  = 2'd1,
    MODE_CAM1  = 2'd2,
    MODE_SPLIT = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_BLANK   = 2'd2
  } state_e;

  typedef struct packed {
    logic splicing;
    logic cmos1;
    logic cmos0;
  } enables_t;

  // Splice is only honoured when both cameras are requested with it.
  function automatic mode_e decode_request(input logic c0, input logic c1, input logic splice);
    if (splice && c0 && c1) return MODE_SPLIT;
    else if (c0)            return MODE_CAM0;
    else if (c1)            return MODE_CAM1;
    else                    return MODE_NONE;
  endfunction

  function automatic enables_t mode_to_enables(input mode_e m);
    enables_t en;
    en = '0;
    case (m)
      MODE_CAM0:  en.cmos0 = 1'b1;
      MODE_CAM1:  en.cmos1 = 1'b1;
      MODE_SPLIT: en = '1;
      default:    en = '0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/display_mode_ctrl_sync_debounce.sv
// Two-flop synchronizers for the GPIO requests and vsync, plus a saturating
// stability counter that turns the decoded request into a debounced req_mode.
module sync_debounce
  import display_mode_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1024
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  cmos0_req_i,
  input  logic  cmos1_req_i,
  input  logic  splicing_req_i,
  input  logic  vsync_i,
  output mode_e req_mode_o,
  output logic  vsync_sync_o
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [3:0]    meta_q;
  logic [3:0]    sync_q;
  mode_e         dec;
  mode_e         prev_q;
  mode_e         req_q;
  mode_e         req_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= {vsync_i, splicing_req_i, cmos1_req_i, cmos0_req_i};
      sync_q <= meta_q;
    end
  end

  assign dec = decode_request(sync_q[0], sync_q[1], sync_q[2]);

  // Any change of the decoded request restarts the count; the count then holds
  // at its maximum so a long-stable request never re-triggers a reload.
  always_comb begin
    cnt_d = cnt_q;
    req_d = req_q;
    if (dec != prev_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
    if ((dec == prev_q) && (cnt_d == CNT_MAX)) begin
      req_d = dec;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= MODE_NONE;
      cnt_q  <= '0;
      req_q  <= MODE_NONE;
    end else begin
      prev_q <= dec;
      cnt_q  <= cnt_d;
      req_q  <= req_d;
    end
  end

  assign req_mode_o   = req_q;
  assign vsync_sync_o = sync_q[3];

endmodule

// File: rtl/display_mode_ctrl.sv
// Display-mode controller: applies debounced GPIO mode requests at frame
// boundaries and blanks the graphics pipeline for a few frames after each switch.
module display_mode_ctrl
  import display_mode_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned BLANK_FRAMES  = 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       gpio_cmos0_en,
  input  logic       gpio_cmos1_en,
  input  logic       gpio_splicing_en,
  input  logic       disp_vsync,
  output logic       cmos0_en,
  output logic       cmos1_en,
  output logic       splicing_en,
  output logic [1:0] mode,
  output logic       mode_switch,
  output logic       blank
);

  localparam int unsigned FW = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLANK_FRAMES - 1);

  mode_e         req_mode;
  logic          vsync_sync;
  logic          vs_prev_q;
  logic          vs_evt_q;
  state_e        state_q;
  state_e        state_d;
  mode_e         mode_q;
  mode_e         mode_d;
  logic [FW-1:0] frame_q;
  logic [FW-1:0] frame_d;
  logic          switch_q;
  logic          switch_d;
  logic          blank_q;
  logic          blank_d;
  enables_t      en_q;
  enables_t      en_d;

  sync_debounce #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_sync_debounce (
    .clk_i         (sys_clk),
    .rst_ni        (sys_rst_n),
    .cmos0_req_i   (gpio_cmos0_en),
    .cmos1_req_i   (gpio_cmos1_en),
    .splicing_req_i(gpio_splicing_en),
    .vsync_i       (disp_vsync),
    .req_mode_o    (req_mode),
    .vsync_sync_o  (vsync_sync)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vs_prev_q <= 1'b0;
      vs_evt_q  <= 1'b0;
    end else begin
      vs_prev_q <= vsync_sync;
      vs_evt_q  <= vsync_sync & ~vs_prev_q;
    end
  end

  // The switching vsync is not counted as a blank frame; the counter starts
  // from the next event seen while already in BLANK.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    frame_d  = frame_q;
    switch_d = 1'b0;
    blank_d  = blank_q;
    case (state_q)
      ST_RUN: begin
        if (req_mode != mode_q) state_d = ST_WAIT_VS;
      end
      ST_WAIT_VS: begin
        if (req_mode == mode_q) begin
          state_d = ST_RUN;
        end else if (vs_evt_q) begin
          mode_d   = req_mode;
          switch_d = 1'b1;
          frame_d  = '0;
          blank_d  = 1'b1;
          state_d  = ST_BLANK;
        end
      end
      ST_BLANK: begin
        if (vs_evt_q) begin
          if (frame_q == FRAME_LAST) begin
            blank_d = 1'b0;
            state_d = ST_RUN;
          end else begin
            frame_d = frame_q + FW'(1);
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign en_d = mode_to_enables(mode_d);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= ST_RUN;
      mode_q   <= MODE_NONE;
      frame_q  <= '0;
      switch_q <= 1'b0;
      blank_q  <= 1'b0;
      en_q     <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      frame_q  <= frame_d;
      switch_q <= switch_d;
      blank_q  <= blank_d;
      en_q     <= en_d;
    end
  end

  assign cmos0_en    = en_q.cmos0;
  assign cmos1_en    = en_q.cmos1;
  assign splicing_en = en_q.splicing;
  assign mode        = mode_q;
  assign mode_switch = switch_q;
  assign blank       = blank_q;

endmodule

// File: tb/tb_display_mode_ctrl.sv
// Scoreboard bench for display_mode_ctrl: expected mode/enables are queued when a
// switch is provoked and compared when the DUT pulses mode_switch.
module tb_display_mode_ctrl;

  localparam int unsigned STABLE = 16;
  localparam int unsigned BLANKF = 2;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [2:0] gpioReq;
  logic       disp_vsync;
  logic       cmos0_en;
  logic       cmos1_en;
  logic       splicing_en;
  logic [1:0] mode;
  logic       mode_switch;
  logic       blank;

  int testsRun;
  int testsFailed;
  logic [4:0] expQ[$];
  logic [4:0] expItem;
  logic       prevSwitch;

  display_mode_ctrl #(
    .STABLE_CYCLES(STABLE),
    .BLANK_FRAMES (BLANKF)
  ) dut (
    .sys_clk         (sys_clk),
    .sys_rst_n       (sys_rst_n),
    .gpio_cmos0_en   (gpioReq[0]),
    .gpio_cmos1_en   (gpioReq[1]),
    .gpio_splicing_en(gpioReq[2]),
    .disp_vsync      (disp_vsync),
    .cmos0_en        (cmos0_en),
    .cmos1_en        (cmos1_en),
    .splicing_en     (splicing_en),
    .mode            (mode),
    .mode_switch     (mode_switch),
    .blank           (blank)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Hold a request long enough for synchronizer plus debounce to accept it.
  task automatic applyStimulus(input logic [2:0] req);
    gpioReq = req;
    waitCycles(STABLE + 14);
  endtask

  task automatic pulseVsync();
    disp_vsync = 1'b1;
    waitCycles(4);
    disp_vsync = 1'b0;
    waitCycles(10);
  endtask

  task automatic pushExpected(input logic [1:0] m, input logic [2:0] en);
    expQ.push_back({m, en});
  endtask

  // Full switch: request, one vsync to apply, then walk through the blank frames.
  task automatic doSwitch(input string tag, input logic [2:0] req, input logic [1:0] m, input logic [2:0] en);
    applyStimulus(req);
    checkOutput({tag, "_held"}, {30'd0, mode}, {30'd0, 2'(m == 2'd0 ? 2'd1 : 2'd0) ^ mode} ^ {30'd0, 2'(m == 2'd0 ? 2'd1 : 2'd0)});
    pushExpected(m, en);
    pulseVsync();
    checkOutput({tag, "_drained"}, expQ.size(), 0);
    checkOutput({tag, "_blank0"}, blank, 1);
    pulseVsync();
    checkOutput({tag, "_blank1"}, blank, 1);
    pulseVsync();
    checkOutput({tag, "_blank2"}, blank, 0);
    checkOutput({tag, "_mode"}, mode, m);
  endtask

  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      prevSwitch = 1'b0;
    end else begin
      if (prevSwitch) checkOutput("switch_width", mode_switch, 0);
      if (mode_switch) begin
        checkOutput("sb_pending", expQ.size() != 0, 1);
        if (expQ.size() != 0) begin
          expItem = expQ.pop_front();
          checkOutput("sb_mode", mode, expItem[4:3]);
          checkOutput("sb_enables", {splicing_en, cmos1_en, cmos0_en}, expItem[2:0]);
          checkOutput("sb_blank", blank, 1);
        end
      end
      prevSwitch = mode_switch;
    end
  end

  initial begin
    logic [1:0] heldMode;
    testsRun    = 0;
    testsFailed = 0;
    prevSwitch  = 1'b0;
    gpioReq     = 3'b000;
    disp_vsync  = 1'b0;
    sys_rst_n   = 1'b0;
    waitCycles(3);
    checkOutput("rst_mode", mode, 0);
    checkOutput("rst_enables", {splicing_en, cmos1_en, cmos0_en}, 0);
    checkOutput("rst_switch", mode_switch, 0);
    checkOutput("rst_blank", blank, 0);
    sys_rst_n = 1'b1;
    waitCycles(3);

    // CAM0: mode must not move before the vsync arrives.
    applyStimulus(3'b001);
    checkOutput("cam0_wait_vsync", mode, 0);
    pushExpected(2'd1, 3'b001);
    pulseVsync();
    checkOutput("cam0_drained", expQ.size(), 0);
    checkOutput("cam0_blank0", blank, 1);
    pulseVsync();
    checkOutput("cam0_blank1", blank, 1);
    pulseVsync();
    checkOutput("cam0_blank2", blank, 0);

    doSwitch("split", 3'b111, 2'd3, 3'b111);
    doSwitch("none", 3'b100, 2'd0, 3'b000);

    // Requests that never stay stable long enough must not switch anything.
    for (int i = 0; i < 50; i++) begin
      gpioReq = (i % 2 == 0) ? 3'b001 : 3'b000;
      if (i % 10 == 5) begin
        disp_vsync = 1'b1;
        waitCycles(4);
        disp_vsync = 1'b0;
        waitCycles(6);
      end else begin
        waitCycles(10);
      end
    end
    gpioReq = 3'b000;
    pulseVsync();
    checkOutput("toggle_mode", mode, 0);

    // Cancelled request: CAM0 -> CAM1 -> CAM0 before any vsync.
    doSwitch("cam0b", 3'b001, 2'd1, 3'b001);
    applyStimulus(3'b010);
    applyStimulus(3'b001);
    pulseVsync();
    checkOutput("cancel_mode", mode, 1);
    checkOutput("cancel_blank", blank, 0);

    // Request SPLIT while blanking after CAM0 -> CAM1.
    applyStimulus(3'b010);
    pushExpected(2'd2, 3'b010);
    pulseVsync();
    checkOutput("cam1_drained", expQ.size(), 0);
    applyStimulus(3'b111);
    checkOutput("blankreq_mode0", mode, 2);
    pulseVsync();
    checkOutput("blankreq_mode1", mode, 2);
    checkOutput("blankreq_blank1", blank, 1);
    pulseVsync();
    checkOutput("blankreq_mode2", mode, 2);
    checkOutput("blankreq_blank2", blank, 0);
    pushExpected(2'd3, 3'b111);
    pulseVsync();
    checkOutput("blankreq_drained", expQ.size(), 0);
    pulseVsync();
    pulseVsync();
    checkOutput("blankreq_final", blank, 0);

    // Reset in the middle of BLANK with mode CAM1.
    applyStimulus(3'b010);
    pushExpected(2'd2, 3'b010);
    pulseVsync();
    checkOutput("prerst_blank", blank, 1);
    @(posedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    #1;
    checkOutput("midrst_mode", mode, 0);
    checkOutput("midrst_enables", {splicing_en, cmos1_en, cmos0_en}, 0);
    checkOutput("midrst_blank", blank, 0);
    checkOutput("midrst_switch", mode_switch, 0);
    waitCycles(3);
    sys_rst_n = 1'b1;
    heldMode = mode;
    pulseVsync();
    checkOutput("postrst_mode", mode, 0);
    checkOutput("postrst_blank", blank, 0);
    checkOutput("postrst_held", heldMode, 0);
    waitCycles(STABLE);
    pushExpected(2'd2, 3'b010);
    pulseVsync();
    checkOutput("postrst_drained", expQ.size(), 0);
    checkOutput("postrst_switched", mode, 2);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule
